// File: rtl/sub_flag_stage.sv
// sub_flag_stage: registered output stage behind the WIDTH-bit borrow-ripple
// subtractor. It captures the difference and the borrow, derives the N/Z/C/V
// flags on the input side, and presents them downstream through a valid/ready
// handshake. A two-entry skid buffer (main + skid) decouples in_ready from
// out_ready, so upstream is never stalled combinationally by downstream.
// A sticky signed-overflow flag is kept for software polling.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   in_valid / in_ready      upstream handshake (in_ready is registered)
//   diff, borrow_out         subtractor difference and final borrow
//   a_msb, b_msb             operand sign bits for the overflow flag
//   out_valid / out_ready    downstream handshake
//   result, flag_n/z/c/v     registered difference and condition flags
//   ovf_sticky, ovf_clear    sticky overflow flag and its clear
module sub_flag_stage #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] diff,
    input  logic             borrow_out,
    input  logic             a_msb,
    input  logic             b_msb,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             flag_n,
    output logic             flag_z,
    output logic             flag_c,
    output logic             flag_v,
    output logic             ovf_sticky,
    input  logic             ovf_clear
);

    localparam int unsigned MSB = WIDTH - 1;

    typedef struct packed {
        logic [WIDTH-1:0] value;
        logic             n;
        logic             z;
        logic             c;
        logic             v;
    } entry_t;

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_FULL1 = 2'd1,
        S_FULL2 = 2'd2
    } state_t;

    state_t state;
    state_t state_nx;
    entry_t main_q;
    entry_t skid_q;
    entry_t in_entry;

    logic accept;
    logic emit;
    logic load_main;
    logic load_skid;
    logic move_skid;

    // Flags are derived from the subtractor outputs and stored with the data.
    always_comb begin
        in_entry.value = diff;
        in_entry.n     = diff[MSB];
        in_entry.z     = ~|diff;
        in_entry.c     = borrow_out;
        in_entry.v     = (a_msb ^ b_msb) & (a_msb ^ diff[MSB]);
    end

    assign accept = in_valid & in_ready;
    assign emit   = out_valid & out_ready;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_EMPTY;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state and buffer-steering decode.
    always_comb begin
        state_nx  = state;
        load_main = 1'b0;
        load_skid = 1'b0;
        move_skid = 1'b0;
        unique case (state)
            S_EMPTY: begin
                if (accept) begin
                    state_nx  = S_FULL1;
                    load_main = 1'b1;
                end
            end
            S_FULL1: begin
                if (accept && emit) begin
                    load_main = 1'b1;
                end else if (emit) begin
                    state_nx = S_EMPTY;
                end else if (accept) begin
                    state_nx  = S_FULL2;
                    load_skid = 1'b1;
                end
            end
            S_FULL2: begin
                // in_ready is low here, so accept cannot fire.
                if (emit) begin
                    state_nx  = S_FULL1;
                    move_skid = 1'b1;
                end
            end
            default: begin
                state_nx = S_EMPTY;
            end
        endcase
    end

    // Handshake flops track the next state so both ports come straight from flops.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            out_valid <= (state_nx != S_EMPTY);
            in_ready  <= (state_nx != S_FULL2);
        end
    end

    // Data storage; entries load only on accept, so idle-cycle X never lands.
    always_ff @(posedge clk) begin
        if (rst) begin
            main_q <= '0;
            skid_q <= '0;
        end else begin
            if (load_main) begin
                main_q <= in_entry;
            end else if (move_skid) begin
                main_q <= skid_q;
            end
            if (load_skid) begin
                skid_q <= in_entry;
            end
        end
    end

    // Sticky overflow: a new overflow wins over a simultaneous clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_sticky <= 1'b0;
        end else if (accept && in_entry.v) begin
            ovf_sticky <= 1'b1;
        end else if (ovf_clear) begin
            ovf_sticky <= 1'b0;
        end
    end

    assign result = main_q.value;
    assign flag_n = main_q.n;
    assign flag_z = main_q.z;
    assign flag_c = main_q.c;
    assign flag_v = main_q.v;

endmodule
